// File: rtl/tc_pl_acp_arb.sv
// Two-requester round-robin arbiter for the shared ACP0 write port.
// Grants one burst at a time, forwards its header and routes beat requests/data.
module tc_pl_acp_arb #(
  parameter int BURST_LEN = 16,
  parameter int TO_CYC    = 1024,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64
) (
  input  logic              clk125,
  input  logic              rst,
  input  logic              req0_tx_en,
  input  logic              req1_tx_en,
  output logic              req0_tx_rdy,
  output logic              req1_tx_rdy,
  input  logic [ADDR_W-1:0] req0_tx_awaddr,
  input  logic [ADDR_W-1:0] req1_tx_awaddr,
  input  logic [2:0]        req0_tx_awid,
  input  logic [2:0]        req1_tx_awid,
  input  logic [DATA_W-1:0] req0_tx_wdata,
  input  logic [DATA_W-1:0] req1_tx_wdata,
  output logic              req0_tx_wdreq,
  output logic              req1_tx_wdreq,
  output logic              acp0_tx_en,
  input  logic              acp0_tx_rdy,
  output logic [ADDR_W-1:0] acp0_tx_awaddr,
  output logic [2:0]        acp0_tx_awid,
  output logic [DATA_W-1:0] acp0_tx_wdata,
  input  logic              acp0_tx_wdreq,
  output logic [1:0]        arb_grant,
  output logic              arb_busy,
  output logic              arb_err
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int IDLE_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    TAIL  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [BEAT_W-1:0]   beat_r;
  logic [IDLE_W-1:0]   idle_r;
  logic                prio_r;
  logic                win_s;
  logic                start_s;
  logic                timeout_s;
  logic                in_data_s;
  logic                wdata_on_s;

  // The last beat is sampled by the port one cycle after its wdreq, so TAIL keeps the data mux.
  assign in_data_s     = (state_r == DATA);
  assign wdata_on_s    = (state_r == DATA) || (state_r == TAIL);
  assign req0_tx_wdreq = in_data_s & arb_grant[0] & acp0_tx_wdreq;
  assign req1_tx_wdreq = in_data_s & arb_grant[1] & acp0_tx_wdreq;
  assign acp0_tx_wdata = wdata_on_s ? (arb_grant[1] ? req1_tx_wdata : req0_tx_wdata)
                                    : {DATA_W{1'b0}};

  // Winner selection and next-state decode
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    timeout_s = 1'b0;
    win_s     = 1'b0;
    if (req0_tx_en && req1_tx_en) begin
      win_s = prio_r;
    end else if (req1_tx_en) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    case (state_r)
      IDLE: begin
        if (acp0_tx_rdy && (req0_tx_en || req1_tx_en)) begin
          start_s = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = DATA;
      DATA: begin
        if (acp0_tx_wdreq) begin
          if (beat_r == BEAT_W'(BURST_LEN - 1)) begin
            state_s = TAIL;
          end else begin
            state_s = DATA;
          end
        end else if (idle_r == IDLE_W'(TO_CYC - 2)) begin
          // this cycle is the (TO_CYC-1)th consecutive one without a beat request
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = DATA;
        end
      end
      TAIL:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered header, grant, status outputs and round-robin pointer
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      acp0_tx_en     <= 1'b0;
      req0_tx_rdy    <= 1'b0;
      req1_tx_rdy    <= 1'b0;
      acp0_tx_awaddr <= {ADDR_W{1'b0}};
      acp0_tx_awid   <= 3'd0;
      arb_grant      <= 2'b00;
      arb_busy       <= 1'b0;
      arb_err        <= 1'b0;
      prio_r         <= 1'b0;
    end else begin
      acp0_tx_en  <= start_s;
      req0_tx_rdy <= start_s & ~win_s;
      req1_tx_rdy <= start_s & win_s;
      arb_busy    <= (state_s != IDLE);
      arb_err     <= timeout_s;
      if (start_s) begin
        acp0_tx_awaddr <= win_s ? req1_tx_awaddr : req0_tx_awaddr;
        acp0_tx_awid   <= win_s ? req1_tx_awid : req0_tx_awid;
        arb_grant      <= win_s ? 2'b10 : 2'b01;
        prio_r         <= ~win_s;
      end else if (state_s == IDLE) begin
        arb_grant <= 2'b00;
      end
    end
  end

  // Beat counter and stall watchdog
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      beat_r <= {BEAT_W{1'b0}};
      idle_r <= {IDLE_W{1'b0}};
    end else if (state_r == ISSUE) begin
      beat_r <= {BEAT_W{1'b0}};
      idle_r <= {IDLE_W{1'b0}};
    end else if (state_r == DATA) begin
      if (acp0_tx_wdreq) begin
        beat_r <= beat_r + BEAT_W'(1);
        idle_r <= {IDLE_W{1'b0}};
      end else begin
        idle_r <= idle_r + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tc_pl_acp_arb.sv
// Scoreboard bench for tc_pl_acp_arb: a burst-level driver pushes expected headers,
// beats and timeout errors; independent monitors pop and compare on DUT activity.
module tb_tc_pl_acp_arb;
  localparam int BL = 16;
  localparam int TO = 8;
  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct { int cyc; logic [1:0] gnt; logic [AW-1:0] addr; logic [2:0] id; } hdr_t;
  typedef struct { int cyc; logic [1:0] gnt; logic [DW-1:0] data; } beat_t;

  logic clk125 = 1'b0;
  logic rst;
  logic req0_tx_en, req1_tx_en, req0_tx_rdy, req1_tx_rdy;
  logic [AW-1:0] req0_tx_awaddr, req1_tx_awaddr, acp0_tx_awaddr;
  logic [2:0] req0_tx_awid, req1_tx_awid, acp0_tx_awid;
  logic [DW-1:0] req0_tx_wdata, req1_tx_wdata, acp0_tx_wdata;
  logic req0_tx_wdreq, req1_tx_wdreq, acp0_tx_en, acp0_tx_rdy, acp0_tx_wdreq;
  logic [1:0] arb_grant;
  logic arb_busy, arb_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int prio_m = 0;
  hdr_t  hdr_q[$];
  beat_t beat_q[$];
  int    err_q[$];
  hdr_t  mon_h;
  beat_t mon_b;

  tc_pl_acp_arb #(.BURST_LEN(BL), .TO_CYC(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk125(clk125), .rst(rst),
    .req0_tx_en(req0_tx_en), .req1_tx_en(req1_tx_en),
    .req0_tx_rdy(req0_tx_rdy), .req1_tx_rdy(req1_tx_rdy),
    .req0_tx_awaddr(req0_tx_awaddr), .req1_tx_awaddr(req1_tx_awaddr),
    .req0_tx_awid(req0_tx_awid), .req1_tx_awid(req1_tx_awid),
    .req0_tx_wdata(req0_tx_wdata), .req1_tx_wdata(req1_tx_wdata),
    .req0_tx_wdreq(req0_tx_wdreq), .req1_tx_wdreq(req1_tx_wdreq),
    .acp0_tx_en(acp0_tx_en), .acp0_tx_rdy(acp0_tx_rdy),
    .acp0_tx_awaddr(acp0_tx_awaddr), .acp0_tx_awid(acp0_tx_awid),
    .acp0_tx_wdata(acp0_tx_wdata), .acp0_tx_wdreq(acp0_tx_wdreq),
    .arb_grant(arb_grant), .arb_busy(arb_busy), .arb_err(arb_err)
  );

  always #4 clk125 = ~clk125;
  always @(posedge clk125) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Header monitor
  always @(negedge clk125) begin
    if (acp0_tx_en || req0_tx_rdy || req1_tx_rdy) begin
      if (hdr_q.size() == 0) begin
        check("hdr_unexpected", {acp0_tx_en, req1_tx_rdy, req0_tx_rdy}, 128'd0);
      end else begin
        mon_h = hdr_q.pop_front();
        check("hdr_cycle", cyc, mon_h.cyc);
        check("hdr_strobe", acp0_tx_en, 1'b1);
        check("hdr_grant", arb_grant, mon_h.gnt);
        check("hdr_rdy", {req1_tx_rdy, req0_tx_rdy}, mon_h.gnt);
        check("hdr_addr", acp0_tx_awaddr, mon_h.addr);
        check("hdr_id", acp0_tx_awid, mon_h.id);
      end
    end
  end

  // Beat monitor
  always @(negedge clk125) begin
    if (req0_tx_wdreq || req1_tx_wdreq) begin
      if (beat_q.size() == 0) begin
        check("beat_unexpected", {req1_tx_wdreq, req0_tx_wdreq}, 128'd0);
      end else begin
        mon_b = beat_q.pop_front();
        check("beat_cycle", cyc, mon_b.cyc);
        check("beat_route", {req1_tx_wdreq, req0_tx_wdreq}, mon_b.gnt);
        check("beat_wdata", acp0_tx_wdata, mon_b.data);
      end
    end
  end

  // Timeout monitor
  always @(negedge clk125) begin
    if (arb_err) begin
      if (err_q.size() == 0) check("err_unexpected", arb_err, 128'd0);
      else check("err_cycle", cyc, err_q.pop_front());
    end
  end

  task automatic drive_cycle(input bit wr, input bit rdy, input int w);
    beat_t b;
    @(posedge clk125); #1;
    acp0_tx_wdreq = wr;
    acp0_tx_rdy   = rdy;
    req0_tx_wdata = {$urandom, $urandom};
    req1_tx_wdata = {$urandom, $urandom};
    req0_tx_en    = 1'($urandom_range(0, 1));
    req1_tx_en    = 1'($urandom_range(0, 1));
    if (wr) begin
      b.cyc  = cyc;
      b.gnt  = (w == 1) ? 2'b10 : 2'b01;
      b.data = (w == 1) ? req1_tx_wdata : req0_tx_wdata;
      beat_q.push_back(b);
    end
  endtask

  task automatic run_burst(input logic [1:0] ens, input int stall, input int nbeats,
                           input int mingap, input int maxgap, input bit do_rst,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [2:0] i0, input logic [2:0] i1);
    int w;
    int last;
    bit r;
    logic [1:0] gnt;
    hdr_t h;
    @(posedge clk125); #1;
    acp0_tx_rdy = 1'b0; acp0_tx_wdreq = 1'b0;
    req0_tx_en = ens[0]; req1_tx_en = ens[1];
    req0_tx_awaddr = a0; req1_tx_awaddr = a1;
    req0_tx_awid = i0;   req1_tx_awid = i1;
    w   = (ens == 2'b11) ? prio_m : (ens[1] ? 1 : 0);
    gnt = (w == 1) ? 2'b10 : 2'b01;
    @(negedge clk125);
    check("idle_before", {arb_busy, arb_grant}, 128'd0);
    repeat (stall) begin
      @(posedge clk125); #1;
      acp0_tx_wdreq = 1'($urandom_range(0, 1));
    end
    if (stall > 0) begin
      @(negedge clk125);
      check("stall_nogrant", {acp0_tx_en, arb_busy, arb_grant}, 128'd0);
    end
    @(posedge clk125); #1;
    acp0_tx_rdy = 1'b1; acp0_tx_wdreq = 1'b0;
    h.cyc = cyc + 1; h.gnt = gnt;
    h.addr = (w == 1) ? a1 : a0;
    h.id   = (w == 1) ? i1 : i0;
    hdr_q.push_back(h);
    prio_m = 1 - w;
    @(posedge clk125); #1;
    last = cyc;
    r = 1'($urandom_range(0, 1));
    acp0_tx_rdy   = (nbeats == 0) ? 1'b0 : r;
    acp0_tx_wdreq = 1'($urandom_range(0, 1));
    req0_tx_en    = 1'($urandom_range(0, 1));
    req1_tx_en    = 1'($urandom_range(0, 1));
    for (int b = 0; b < nbeats; b++) begin
      int g;
      g = $urandom_range(mingap, maxgap);
      repeat (g) drive_cycle(1'b0, 1'($urandom_range(0, 1)), w);
      r = 1'($urandom_range(0, 1));
      drive_cycle(1'b1, (b == nbeats - 1) ? 1'b0 : r, w);
      last = cyc;
    end
    if (nbeats == BL) begin
      @(posedge clk125); #1;
      acp0_tx_wdreq = 1'($urandom_range(0, 1));
      acp0_tx_rdy = 1'b0;
      req0_tx_wdata = {$urandom, $urandom};
      req1_tx_wdata = {$urandom, $urandom};
      @(negedge clk125);
      check("tail_wdata", acp0_tx_wdata, (w == 1) ? req1_tx_wdata : req0_tx_wdata);
      check("tail_busy", {arb_busy, arb_grant}, {1'b1, gnt});
      @(posedge clk125); #1;
      acp0_tx_wdreq = 1'($urandom_range(0, 1));
      @(negedge clk125);
      check("end_idle", {arb_busy, arb_grant, acp0_tx_wdata}, 128'd0);
    end else if (do_rst) begin
      @(posedge clk125); #1;
      acp0_tx_wdreq = 1'b0;
      rst = 1'b1;
      #2;
      check("rst_async", {acp0_tx_en, req0_tx_rdy, req1_tx_rdy, req0_tx_wdreq, req1_tx_wdreq,
                          acp0_tx_awaddr, acp0_tx_awid, acp0_tx_wdata, arb_grant, arb_busy,
                          arb_err}, 128'd0);
      prio_m = 0;
      @(posedge clk125); #1;
      rst = 1'b0;
    end else begin
      err_q.push_back(last + TO);
      while (cyc < last + TO) begin
        @(posedge clk125); #1;
        acp0_tx_wdreq = 1'b0; acp0_tx_rdy = 1'b0;
      end
      @(negedge clk125);
      check("abort_idle", {arb_busy, arb_grant}, 128'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_tx_en = 1'b0; req1_tx_en = 1'b0;
    req0_tx_awaddr = 32'd0; req1_tx_awaddr = 32'd0;
    req0_tx_awid = 3'd0; req1_tx_awid = 3'd0;
    req0_tx_wdata = 64'd0; req1_tx_wdata = 64'd0;
    acp0_tx_rdy = 1'b0; acp0_tx_wdreq = 1'b0;
    repeat (3) @(posedge clk125);
    #1;
    check("reset_state", {acp0_tx_en, req0_tx_rdy, req1_tx_rdy, req0_tx_wdreq, req1_tx_wdreq,
                          acp0_tx_awaddr, acp0_tx_awid, acp0_tx_wdata, arb_grant, arb_busy,
                          arb_err}, 128'd0);
    rst = 1'b0;

    run_burst(2'b01, 0, BL, 0, 0, 1'b0, 32'h1000_0000, $urandom, 3'd2, 3'd5);
    repeat (4) run_burst(2'b11, 0, BL, 0, 1, 1'b0, $urandom, $urandom,
                         3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    run_burst(2'b10, 20, BL, 0, 2, 1'b0, $urandom, $urandom, 3'd1, 3'd6);
    run_burst(2'b01, 0, BL, 2, 2, 1'b0, $urandom, $urandom, 3'd3, 3'd4);
    run_burst(2'b01, 0, BL, TO - 2, TO - 2, 1'b0, $urandom, $urandom, 3'd7, 3'd0);
    run_burst(2'b01, 0, 5, 0, 1, 1'b0, $urandom, $urandom, 3'd2, 3'd3);
    run_burst(2'b11, 0, BL, 0, 1, 1'b0, $urandom, $urandom, 3'd4, 3'd5);
    run_burst(2'b01, 0, 7, 0, 1, 1'b1, $urandom, $urandom, 3'd1, 3'd2);
    run_burst(2'b11, 0, BL, 0, 1, 1'b0, $urandom, $urandom, 3'd6, 3'd7);
    run_burst(2'b10, 0, BL, 0, 1, 1'b0, $urandom, $urandom, 3'd0, 3'd1);

    for (int k = 0; k < 40; k++) begin
      int nb;
      int mg;
      nb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, BL - 1) : BL;
      mg = ($urandom_range(0, 3) == 0) ? TO - 2 : 2;
      run_burst(2'($urandom_range(1, 3)), $urandom_range(0, 3), nb, 0, mg,
                1'($urandom_range(0, 9) == 0), $urandom, $urandom,
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    repeat (3) @(posedge clk125);
    #1;
    check("hdr_q_drained", hdr_q.size(), 128'd0);
    check("beat_q_drained", beat_q.size(), 128'd0);
    check("err_q_drained", err_q.size(), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
